// File: rtl/rom_bus_arbiter_pkg.sv
// Shared types for the ROM/RAM bus arbiter: transfer size, FSM state and
// a helper for sizing the timeout counter.
package rom_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Counter must hold TIMEOUT itself (it increments on the last BUSY cycle).
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rom_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one memory slave between an instruction-fetch and a data/debug
// requester; holds the grant until bdone or timeout, then pulses done.
//
// state | meaning
// IDLE  | no owner, sampling req for a new grant
// BUSY  | owner's payload on the slave bus, waiting for bdone/timeout
// DONE  | one-cycle done/err pulse to the owner
module rom_bus_arbiter
  import rom_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [1:0][AW-1:0]   addr,
  input  logic [1:0]           write,
  input  logic [1:0][DW-1:0]   wdata,
  input  tsize_t [1:0]         tsize,
  output logic [1:0][DW-1:0]   rdata,
  output logic [1:0]           done,
  output logic [1:0]           err,
  output logic                 m_req,
  output logic [AW-1:0]        m_addr,
  output logic                 m_write,
  output logic [DW-1:0]        m_wdata,
  output tsize_t               m_tsize,
  input  logic [DW-1:0]        m_rdata,
  input  logic                 m_bdone
);

  localparam int unsigned   CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TC = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_t    state, state_nx;
  logic          owner, last;
  logic          grant, grant_valid;
  logic [CW-1:0] cnt;
  logic          timed_out, finish;

  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [DW-1:0] wdata_q;
  tsize_t        tsize_q;

  rr_arb2 u_pick (
    .req   (req),
    .last  (last),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    state_nx  = state;
    finish    = 1'b0;
    timed_out = (TIMEOUT != 0) && (cnt == TC) && !m_bdone;
    case (state)
      IDLE: if (grant_valid) state_nx = BUSY;
      BUSY: begin
        if (m_bdone || timed_out) begin
          state_nx = DONE;
          finish   = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Slave bus follows the owner live in BUSY and parks on the last payload otherwise.
  assign m_req   = (state == BUSY);
  assign m_addr  = m_req ? addr[owner]  : addr_q;
  assign m_write = m_req ? write[owner] : write_q;
  assign m_wdata = m_req ? wdata[owner] : wdata_q;
  assign m_tsize = m_req ? tsize[owner] : tsize_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      rdata   <= '0;
      done    <= '0;
      err     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      tsize_q <= WORD;
    end else begin
      state <= state_nx;
      done  <= '0;
      case (state)
        IDLE: if (grant_valid) owner <= grant;
        BUSY: begin
          cnt     <= cnt + CW'(1);
          addr_q  <= addr[owner];
          write_q <= write[owner];
          wdata_q <= wdata[owner];
          tsize_q <= tsize[owner];
          if (finish) begin
            rdata[owner] <= m_bdone ? m_rdata : '0;
            err[owner]   <= ~m_bdone;
            done[owner]  <= 1'b1;
            last         <= owner;
          end
        end
        DONE:    cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: directed scenarios plus a random
// request/latency mix checked against a transaction-level model.
module tb_rom_bus_arbiter;
  import rom_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           req;
  logic [1:0][AW-1:0]   addr;
  logic [1:0]           write;
  logic [1:0][DW-1:0]   wdata;
  tsize_t [1:0]         tsize;
  logic [1:0][DW-1:0]   rdata;
  logic [1:0]           done, err;
  logic                 m_req, m_write, m_bdone;
  logic [AW-1:0]        m_addr;
  logic [DW-1:0]        m_wdata, m_rdata;
  tsize_t               m_tsize;

  logic [1:0]           t_req;
  logic                 t_bdone;
  logic [1:0][DW-1:0]   t_rdata;
  logic [1:0]           t_done, t_err;
  logic                 t_m_req, t_m_write;
  logic [AW-1:0]        t_m_addr;
  logic [DW-1:0]        t_m_wdata;
  tsize_t               t_m_tsize;

  int tests = 0;
  int fails = 0;

  int                 model_last;
  logic [1:0][DW-1:0] mdl_rdata;
  logic [1:0]         mdl_err;

  always #5 clk = ~clk;

  rom_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .write(write), .wdata(wdata),
    .tsize(tsize), .rdata(rdata), .done(done), .err(err), .m_req(m_req),
    .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_tsize(m_tsize),
    .m_rdata(m_rdata), .m_bdone(m_bdone)
  );

  rom_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst), .req(t_req), .addr(addr), .write(write), .wdata(wdata),
    .tsize(tsize), .rdata(t_rdata), .done(t_done), .err(t_err), .m_req(t_m_req),
    .m_addr(t_m_addr), .m_write(t_m_write), .m_wdata(t_m_wdata), .m_tsize(t_m_tsize),
    .m_rdata(m_rdata), .m_bdone(t_bdone)
  );

  // Tie goes to whoever was not served last; a lone request always wins.
  function automatic int exp_owner(input logic [1:0] r);
    int other;
    other = 1 - model_last;
    if (r[other]) return other;
    return model_last;
  endfunction

  function automatic void mdl_complete(input int o, input bit timed, input logic [DW-1:0] rd);
    mdl_rdata[o] = timed ? '0 : rd;
    mdl_err[o]   = timed;
    model_last   = o;
  endfunction

  function automatic void mdl_reset();
    model_last = 1;
    mdl_rdata  = '0;
    mdl_err    = '0;
  endfunction

  // Acts as the slave: holds bdone low for 'delay' BUSY cycles, then high.
  task automatic do_txn(input int delay, input logic [DW-1:0] rd,
                        output logic [AW-1:0] a_obs, output logic w_obs,
                        output logic [DW-1:0] wd_obs, output tsize_t ts_obs,
                        output int busy, output int lat, output bit stable,
                        output logic [1:0] done_obs, output logic [1:0] err_obs,
                        output logic [1:0] done_after);
    bit seen;
    busy = 0; lat = 0; stable = 1; seen = 0;
    a_obs = '0; w_obs = 1'b0; wd_obs = '0; ts_obs = WORD;
    done_obs = '0; err_obs = '0;
    m_bdone = 1'b0;
    m_rdata = rd;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (done !== 2'b00) begin
        seen = 1;
        done_obs = done;
        err_obs  = err;
        if (m_req !== 1'b0) stable = 0;
      end else if (m_req === 1'b1) begin
        busy++;
        if (busy == 1) begin
          a_obs = m_addr; w_obs = m_write; wd_obs = m_wdata; ts_obs = m_tsize;
        end else if (m_addr !== a_obs || m_write !== w_obs || m_wdata !== wd_obs ||
                     m_tsize !== ts_obs) begin
          stable = 0;
        end
        m_bdone = (busy > delay);
      end
    end
    m_bdone = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL txn_wait: no done within 64 cycles (busy=%0d)", busy);
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic t4_txn(input logic [1:0] r, input bit bd, output int busy,
                        output logic [1:0] d, output logic [1:0] e);
    bit seen;
    busy = 0; seen = 0; d = '0; e = '0;
    t_req = r;
    t_bdone = bd;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (t_done !== 2'b00) begin
        seen = 1; d = t_done; e = t_err;
      end else if (t_m_req === 1'b1) busy++;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL t4_wait: no done within 40 cycles");
    end
    t_req = 2'b00;
    t_bdone = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++; if (rdata !== '0) begin fails++; $display("FAIL %s_rdata: got %h want 0", tag, rdata); end
    tests++; if (done !== 2'b00) begin fails++; $display("FAIL %s_done: got %b want 00", tag, done); end
    tests++; if (err !== 2'b00) begin fails++; $display("FAIL %s_err: got %b want 00", tag, err); end
    tests++; if (m_req !== 1'b0) begin fails++; $display("FAIL %s_m_req: got %b want 0", tag, m_req); end
    tests++; if (m_write !== 1'b0) begin fails++; $display("FAIL %s_m_write: got %b want 0", tag, m_write); end
    tests++; if (m_addr !== '0) begin fails++; $display("FAIL %s_m_addr: got %h want 0", tag, m_addr); end
    tests++; if (m_wdata !== '0) begin fails++; $display("FAIL %s_m_wdata: got %h want 0", tag, m_wdata); end
    tests++; if (m_tsize !== WORD) begin fails++; $display("FAIL %s_m_tsize: got %0d want %0d", tag, m_tsize, WORD); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; addr = '0; write = '0; wdata = '0; tsize = {WORD, WORD};
    m_rdata = '0; m_bdone = 1'b0; t_req = '0; t_bdone = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd; tsize_t ts;
    int busy, lat; bit st; logic [1:0] d, e, da;
    addr[0] = 32'h10; write[0] = 1'b0; tsize[0] = WORD;
    req = 2'b01;
    do_txn(0, 32'hDEADBEEF, a, w, wd, ts, busy, lat, st, d, e, da);
    req = 2'b00;
    mdl_complete(0, 0, 32'hDEADBEEF);
    tests++; if (busy != 1) begin fails++; $display("FAIL single_busy: got %0d want 1", busy); end
    tests++; if (lat != 2) begin fails++; $display("FAIL single_latency: got %0d want 2", lat); end
    tests++; if (a !== 32'h10) begin fails++; $display("FAIL single_m_addr: got %h want 10", a); end
    tests++; if (d !== 2'b01) begin fails++; $display("FAIL single_done: got %b want 01", d); end
    tests++; if (da !== 2'b00) begin fails++; $display("FAIL single_done_width: got %b want 00", da); end
    tests++; if (e !== 2'b00) begin fails++; $display("FAIL single_err: got %b want 00", e); end
    tests++; if (rdata !== mdl_rdata) begin fails++; $display("FAIL single_rdata: got %h want %h", rdata, mdl_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, prev; logic w; logic [DW-1:0] wd, rd; tsize_t ts;
    int busy, lat, o; bit st; logic [1:0] d, e, da;
    time t0;
    addr[0] = 32'h4; addr[1] = 32'h8; write = '0;
    req = 2'b11;
    prev = '0;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      o = exp_owner(req);
      rd = $urandom;
      do_txn(0, rd, a, w, wd, ts, busy, lat, st, d, e, da);
      mdl_complete(o, 0, rd);
      tests++; if (a !== (o == 1 ? 32'h8 : 32'h4)) begin fails++; $display("FAIL b2b_m_addr[%0d]: got %h want owner %0d", i, a, o); end
      tests++; if (d !== (2'b01 << o)) begin fails++; $display("FAIL b2b_done[%0d]: got %b want owner %0d", i, d, o); end
      tests++; if (i > 0 && a === prev) begin fails++; $display("FAIL b2b_alternate[%0d]: got %h twice", i, a); end
      tests++; if (rdata !== mdl_rdata) begin fails++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata, mdl_rdata); end
      prev = a;
    end
    tests++; if ($time - t0 != 120) begin fails++; $display("FAIL b2b_throughput: got %0t want 120 for 4 txns", $time - t0); end
    req = 2'b00;
  endtask

  task automatic test_slow_slave();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd; tsize_t ts;
    int busy, lat; bit st; logic [1:0] d, e, da;
    addr[1] = 32'h20; write[1] = 1'b0; tsize[1] = HALF;
    req = 2'b10;
    do_txn(5, 32'h0BADCAFE, a, w, wd, ts, busy, lat, st, d, e, da);
    req = 2'b00;
    mdl_complete(1, 0, 32'h0BADCAFE);
    tests++; if (busy != 6) begin fails++; $display("FAIL slow_busy: got %0d want 6", busy); end
    tests++; if (!st) begin fails++; $display("FAIL slow_stable: payload moved during BUSY"); end
    tests++; if (lat != busy + 1) begin fails++; $display("FAIL slow_done_latency: got %0d want %0d", lat, busy + 1); end
    tests++; if (d !== 2'b10) begin fails++; $display("FAIL slow_done: got %b want 10", d); end
    tests++; if (e !== mdl_err) begin fails++; $display("FAIL slow_err: got %b want %b", e, mdl_err); end
    tests++; if (rdata !== mdl_rdata) begin fails++; $display("FAIL slow_rdata: got %h want %h", rdata, mdl_rdata); end
  endtask

  task automatic test_write();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd; tsize_t ts;
    int busy, lat; bit st; logic [1:0] d, e, da;
    logic [DW-1:0] rd;
    rd = $urandom;
    addr[1] = 32'h100; write[1] = 1'b1; wdata[1] = 32'h12345678; tsize[1] = BYTE;
    req = 2'b10;
    do_txn(0, rd, a, w, wd, ts, busy, lat, st, d, e, da);
    req = 2'b00;
    mdl_complete(1, 0, rd);
    tests++; if (w !== 1'b1) begin fails++; $display("FAIL write_m_write: got %b want 1", w); end
    tests++; if (wd !== 32'h12345678) begin fails++; $display("FAIL write_m_wdata: got %h want 12345678", wd); end
    tests++; if (ts !== BYTE) begin fails++; $display("FAIL write_m_tsize: got %0d want %0d", ts, BYTE); end
    tests++; if (d !== 2'b10) begin fails++; $display("FAIL write_done: got %b want 10", d); end
    write[1] = 1'b0;
  endtask

  task automatic test_timeout();
    int busy; logic [1:0] d, e;
    addr[0] = 32'h50; addr[1] = 32'h54;
    m_rdata = 32'hCAFEF00D;
    t4_txn(2'b01, 1'b1, busy, d, e);
    tests++; if (t_rdata[0] !== 32'hCAFEF00D) begin fails++; $display("FAIL to_prefill: got %h want cafef00d", t_rdata[0]); end
    t4_txn(2'b01, 1'b0, busy, d, e);
    tests++; if (busy != 4) begin fails++; $display("FAIL to_busy: got %0d want 4", busy); end
    tests++; if (d !== 2'b01) begin fails++; $display("FAIL to_done: got %b want 01", d); end
    tests++; if (e !== 2'b01) begin fails++; $display("FAIL to_err: got %b want 01", e); end
    tests++; if (t_rdata[0] !== '0) begin fails++; $display("FAIL to_rdata: got %h want 0", t_rdata[0]); end
    m_rdata = 32'h600DD00D;
    t4_txn(2'b10, 1'b1, busy, d, e);
    tests++; if (d !== 2'b10) begin fails++; $display("FAIL to_next_done: got %b want 10", d); end
    tests++; if (e !== 2'b01) begin fails++; $display("FAIL to_next_err: got %b want 01", e); end
    tests++; if (t_rdata[1] !== 32'h600DD00D) begin fails++; $display("FAIL to_next_rdata: got %h want 600dd00d", t_rdata[1]); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd; tsize_t ts;
    int busy, lat, nb; bit st; logic [1:0] d, e, da, dseen;
    addr[0] = 32'h30; m_bdone = 1'b0;
    req = 2'b01;
    nb = 0;
    for (int k = 0; k < 10 && nb < 2; k++) begin
      @(negedge clk);
      if (m_req === 1'b1) nb++;
    end
    tests++; if (nb != 2) begin fails++; $display("FAIL rstmid_busy: got %0d busy cycles want 2", nb); end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmid");
    rst = 1'b0;
    req = 2'b00;
    mdl_reset();
    dseen = '0;
    repeat (4) begin
      @(negedge clk);
      dseen = dseen | done;
    end
    tests++; if (dseen !== 2'b00) begin fails++; $display("FAIL rstmid_no_done: got %b want 00", dseen); end
    addr[0] = 32'h40; addr[1] = 32'h44;
    req = 2'b11;
    do_txn(0, 32'h1, a, w, wd, ts, busy, lat, st, d, e, da);
    mdl_complete(0, 0, 32'h1);
    req = 2'b00;
    tests++; if (a !== 32'h40) begin fails++; $display("FAIL rstmid_tie_addr: got %h want 40", a); end
    tests++; if (d !== 2'b01) begin fails++; $display("FAIL rstmid_tie_done: got %b want 01", d); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic w; logic [DW-1:0] wd, rd; tsize_t ts;
    int busy, lat, o, delay, pick, exp_busy; bit st, timed; logic [1:0] d, e, da;
    logic [1:0] pend, fresh;
    pend = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (pend == 2'b00) fresh = 2'($urandom_range(1, 3));
      else fresh = 2'($urandom_range(0, 1)) & ~pend;
      for (int j = 0; j < 2; j++) begin
        if (fresh[j]) begin
          addr[j]  = $urandom;
          write[j] = 1'($urandom_range(0, 1));
          wdata[j] = $urandom;
          tsize[j] = tsize_t'($urandom_range(0, 2));
        end
      end
      pend = pend | fresh;
      req = pend;
      o = exp_owner(pend);
      pick = $urandom_range(0, 9);
      if (pick < 6) delay = $urandom_range(0, 3);
      else if (pick < 8) delay = $urandom_range(TO - 2, TO + 1);
      else delay = $urandom_range(4, TO - 3);
      rd = $urandom;
      do_txn(delay, rd, a, w, wd, ts, busy, lat, st, d, e, da);
      timed = (delay >= TO);
      exp_busy = timed ? TO : delay + 1;
      mdl_complete(o, timed, rd);
      tests++; if (a !== addr[o]) begin fails++; $display("FAIL rnd_m_addr[%0d]: got %h want %h", i, a, addr[o]); end
      tests++; if (w !== write[o]) begin fails++; $display("FAIL rnd_m_write[%0d]: got %b want %b", i, w, write[o]); end
      tests++; if (wd !== wdata[o]) begin fails++; $display("FAIL rnd_m_wdata[%0d]: got %h want %h", i, wd, wdata[o]); end
      tests++; if (ts !== tsize[o]) begin fails++; $display("FAIL rnd_m_tsize[%0d]: got %0d want %0d", i, ts, tsize[o]); end
      tests++; if (busy != exp_busy) begin fails++; $display("FAIL rnd_busy[%0d]: got %0d want %0d (delay %0d)", i, busy, exp_busy, delay); end
      tests++; if (!st) begin fails++; $display("FAIL rnd_stable[%0d]: bus payload or m_req misbehaved", i); end
      tests++; if (d !== (2'b01 << o)) begin fails++; $display("FAIL rnd_done[%0d]: got %b want owner %0d", i, d, o); end
      tests++; if (da !== 2'b00) begin fails++; $display("FAIL rnd_done_width[%0d]: got %b want 00", i, da); end
      tests++; if (e !== mdl_err) begin fails++; $display("FAIL rnd_err[%0d]: got %b want %b", i, e, mdl_err); end
      tests++; if (rdata !== mdl_rdata) begin fails++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rdata, mdl_rdata); end
      pend[o] = 1'b0;
      req = pend;
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_slow_slave();
    test_write();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
